// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with stall/flush, bubble and stall-run counters
// Optional fetch address-error detection is enabled by defining IF_ID_ADEL_EN.
module if_id_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall_D,
  input  logic        Flush_D,
  input  logic [31:0] PC_F,
  input  logic [31:0] instr_F,
  output logic [31:0] PC_D = 32'h0000_3000,
  output logic [31:0] instr_D = 32'h0000_0000,
  output logic [31:0] PC8_D = 32'h0000_3008,
  output logic        valid_D = 1'b0,
  output logic [5:0]  op_D,
  output logic [5:0]  funct_D,
  output logic [4:0]  rs_D,
  output logic [4:0]  rt_D,
  output logic [4:0]  rd_D,
  output logic [4:0]  shamt_D,
  output logic [15:0] imm16_D,
  output logic [25:0] instr_index_D,
`ifdef IF_ID_ADEL_EN
  output logic [4:0]  ExcCode_D = 5'd0,
  output logic        exc_D = 1'b0,
`endif
  output logic [31:0] bubble_cnt = 32'h0000_0000,
  output logic [7:0]  stall_run = 8'h00
);

  logic [31:0] pc8_f;
  logic        adel_f;

  assign pc8_f = PC_F + 32'd8;

`ifdef IF_ID_ADEL_EN
  // Misaligned fetch or fetch outside the instruction memory window.
  assign adel_f = (PC_F[1:0] != 2'b00) || (PC_F < 32'h0000_3000) || (PC_F > 32'h0000_6FFC);
`else
  assign adel_f = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      PC_D       <= 32'h0000_3000;
      PC8_D      <= 32'h0000_3008;
      instr_D    <= 32'h0000_0000;
      valid_D    <= 1'b0;
      bubble_cnt <= 32'h0000_0000;
      stall_run  <= 8'h00;
`ifdef IF_ID_ADEL_EN
      exc_D      <= 1'b0;
      ExcCode_D  <= 5'd0;
`endif
    end else begin
      if (!valid_D && (bubble_cnt != 32'hFFFF_FFFF)) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end

      if (Stall_D) begin
        if (stall_run != 8'hFF) begin
          stall_run <= stall_run + 8'd1;
        end
      end else begin
        stall_run <= 8'h00;
      end

      // Stall wins over flush so a held delay-slot instruction survives.
      if (!Stall_D) begin
        PC_D  <= PC_F;
        PC8_D <= pc8_f;
        if (Flush_D) begin
          instr_D <= 32'h0000_0000;
          valid_D <= 1'b0;
`ifdef IF_ID_ADEL_EN
          exc_D     <= 1'b0;
          ExcCode_D <= 5'd0;
`endif
        end else begin
          instr_D <= adel_f ? 32'h0000_0000 : instr_F;
          valid_D <= 1'b1;
`ifdef IF_ID_ADEL_EN
          exc_D     <= adel_f;
          ExcCode_D <= adel_f ? 5'd4 : 5'd0;
`endif
        end
      end
    end
  end

  assign op_D          = instr_D[31:26];
  assign rs_D          = instr_D[25:21];
  assign rt_D          = instr_D[20:16];
  assign rd_D          = instr_D[15:11];
  assign shamt_D       = instr_D[10:6];
  assign funct_D       = instr_D[5:0];
  assign imm16_D       = instr_D[15:0];
  assign instr_index_D = instr_D[25:0];

endmodule

// File: doc/if_id_reg.md
IF_ID_REG -- requirements
Module: if_id_reg

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port Stall_D, input, 1, hold all D-stage state this cycle.
REQ-004 SHALL have port Flush_D, input, 1, replace the incoming fetch with a bubble.
REQ-005 SHALL have port PC_F, input, 32, fetch-stage PC.
REQ-006 SHALL have port instr_F, input, 32, fetched instruction word.
REQ-007 SHALL have ports PC_D, instr_D, PC8_D, outputs, 32 each: latched PC, latched instruction, latched PC+8 (link address).
REQ-008 SHALL have port valid_D, output, 1, high when D holds a real fetched instruction.
REQ-009 SHALL have ports op_D (6), funct_D (6), rs_D (5), rt_D (5), rd_D (5), shamt_D (5), imm16_D (16), instr_index_D (26), outputs, field slices of instr_D.
REQ-010 SHALL have port bubble_cnt, output, 32, count of cycles in which D held a bubble.
REQ-011 SHALL have port stall_run, output, 8, length of the current consecutive Stall_D run.

Function
REQ-012 Each edge with Stall_D=0, Flush_D=0 SHALL load PC_D<=PC_F, instr_D<=instr_F, PC8_D<=PC_F+8 (mod 2^32), valid_D<=1.
REQ-013 Edge with Stall_D=1 SHALL hold PC_D, instr_D, PC8_D, valid_D unchanged regardless of Flush_D.
REQ-014 Edge with Stall_D=0, Flush_D=1 SHALL load bubble: instr_D<=0, valid_D<=0, PC_D<=PC_F, PC8_D<=PC_F+8.
REQ-015 Priority SHALL be reset > Stall_D > Flush_D > normal load; simultaneous Stall_D and Flush_D keeps the stalled instruction (delay-slot preserved).
REQ-016 Field outputs SHALL be pure combinational slices of instr_D: op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0], imm16[15:0], instr_index[25:0]; zero latency from instr_D.
REQ-017 bubble_cnt SHALL increment by 1 on each edge where valid_D (pre-edge) is 0 and reset is low, saturating at 32'hFFFF_FFFF.
REQ-018 stall_run SHALL increment on each edge with Stall_D=1, saturating at 8'hFF, and SHALL clear to 0 on any edge with Stall_D=0.
REQ-019 Instruction load latency SHALL be exactly one cycle: instr_F sampled at edge N is visible on instr_D after edge N.
REQ-020 PC_F+8 overflow SHALL wrap (32'hFFFF_FFFC -> PC8_D=32'h0000_0004), no flag.

Reset
REQ-021 reset=1 at an edge SHALL set PC_D=32'h0000_3000, PC8_D=32'h0000_3008, instr_D=0, valid_D=0, bubble_cnt=0, stall_run=0, overriding Stall_D and Flush_D.
REQ-022 Reset asserted mid-stall SHALL discard the held instruction; first post-reset load follows REQ-012.
REQ-023 All registers SHALL carry the same reset values as initial values for simulation.

Configuration
REQ-024 Macro IF_ID_ADEL_EN SHALL, when defined, add outputs ExcCode_D (5) and exc_D (1): on a normal load, exc_D<=1 and ExcCode_D<=5'd4 if PC_F[1:0]!=0 or PC_F outside 32'h0000_3000..32'h0000_6FFC; when set, instr_D SHALL be loaded as 0 while valid_D<=1.
REQ-025 With IF_ID_ADEL_EN defined, exc_D/ExcCode_D SHALL hold under stall, clear to 0 on flush and reset.
REQ-026 Without IF_ID_ADEL_EN, those ports and logic SHALL be absent and instr_D SHALL always be instr_F on a normal load.

Verification
REQ-027 Reset release, PC_F=32'h3000, instr_F=32'h3C01_1234, no stall -> after 1 edge PC_D=32'h3000, PC8_D=32'h3008, instr_D=32'h3C01_1234, rt_D=1, imm16_D=16'h1234, valid_D=1.
REQ-028 Stall_D=1 for 3 edges while PC_F advances 32'h3004..32'h300C -> PC_D/instr_D unchanged, stall_run=3, then 0 after first non-stall edge.
REQ-029 Flush_D=1, Stall_D=0, PC_F=32'h3010 -> instr_D=0, valid_D=0, PC_D=32'h3010; next edge bubble_cnt increments by 1.
REQ-030 Stall_D=1 and Flush_D=1 together -> D contents and valid_D=1 held.
REQ-031 reset=1 during Stall_D=1 -> PC_D=32'h3000, instr_D=0, bubble_cnt=0, stall_run=0.
REQ-032 IF_ID_ADEL_EN defined, PC_F=32'h3002 -> exc_D=1, ExcCode_D=4, instr_D=0; PC_F=32'h7000 -> same; PC_F=32'h6FFC -> exc_D=0.
